// File: rtl/seg_display_ctrl.sv
// ============================================================================
// Module  : seg_display_ctrl
// Brief   : Arbitrates the 8-digit hex display between the keyboard scan-code
//           history and an auxiliary 32-bit source, with a minimum hold time.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_display_ctrl #(
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_kb_code,
    input  logic        i_kb_valid,
    input  logic [31:0] i_aux_data,
    input  logic        i_aux_req,
    output logic        o_aux_ack,
    output logic [31:0] o_disp_data,
    output logic        o_disp_owner,
    output logic [7:0]  o_key_count
);

    localparam int HCW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HCW-1:0] c_HOLD_RELOAD = HCW'(HOLD_CYCLES - 1);

    localparam logic [0:0] c_ST_KEY = 1'b0;
    localparam logic [0:0] c_ST_AUX = 1'b1;

    logic [0:0]     r_state;
    logic [31:0]    r_hist;
    logic [HCW-1:0] r_hold_cnt;
    logic           r_kb_pending;

    logic [31:0]    w_hist_next;
    logic           w_hold_done;

    // Keyboard view on any edge includes a byte shifted in on that same edge.
    assign w_hist_next = i_kb_valid ? {r_hist[23:0], i_kb_code} : r_hist;
    assign w_hold_done = (r_hold_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_KEY;
            r_hist       <= '0;
            r_hold_cnt   <= '0;
            r_kb_pending <= 1'b0;
            o_disp_data  <= '0;
            o_disp_owner <= 1'b0;
            o_aux_ack    <= 1'b0;
            o_key_count  <= '0;
        end else begin
            r_hist    <= w_hist_next;
            o_aux_ack <= 1'b0;
            if (i_kb_valid) begin
                o_key_count <= o_key_count + 8'd1;
            end
            if (!w_hold_done) begin
                r_hold_cnt <= r_hold_cnt - HCW'(1);
            end

            case (r_state)
                c_ST_KEY: begin
                    if (i_aux_req && w_hold_done) begin
                        r_state      <= c_ST_AUX;
                        o_disp_data  <= i_aux_data;
                        o_disp_owner <= 1'b1;
                        o_aux_ack    <= 1'b1;
                        r_hold_cnt   <= c_HOLD_RELOAD;
                        r_kb_pending <= i_kb_valid;
                    end else begin
                        o_disp_data  <= w_hist_next;
                        o_disp_owner <= 1'b0;
                    end
                end
                default: begin
                    // Aux release wins over everything; a pending key only preempts once hold expires.
                    if (!i_aux_req || (w_hold_done && r_kb_pending)) begin
                        r_state      <= c_ST_KEY;
                        o_disp_data  <= w_hist_next;
                        o_disp_owner <= 1'b0;
                        r_hold_cnt   <= c_HOLD_RELOAD;
                        r_kb_pending <= 1'b0;
                    end else begin
                        o_disp_data  <= i_aux_data;
                        o_disp_owner <= 1'b1;
                        if (i_kb_valid) begin
                            r_kb_pending <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire
